bist_checker: RTL
=================

# bist_checker

Receive-side built-in self-test block for the router links. Regenerates the transmitter's pseudo-random vector stream from an identical seeded 32-bit LFSR and compares it against arriving channel vectors for `TEST_CASES` vectors. It compensates a fixed link latency, then reports pass/fail, the mismatch count, the first failing vector and which channels failed. After the test it passes link traffic straight through to the router input.

## Interface
- `TEST_CHANNELS`, 70: link width in bits.
- `SEED`, 32'hdeadbeef: LFSR seed; must equal the transmitter's seed.
- `TEST_CASES`, 1000: number of vectors checked; 1 to 2^32-1.
- `LATENCY`, 0: register stages between transmitter output and `input_channels`; 0 to 8.

- `clk`, input, 1: single clock, rising-edge.
- `reset`, input, 1: asynchronous, active-low (0 = reset).
- `input_channels`, input, `TEST_CHANNELS`: vector arriving from the link.
- `output_channels`, output, `TEST_CHANNELS`: pass-through to the router; all zeros until `done`.
- `done`, output, 1: checking complete.
- `pass`, output, 1: `done` and `error_count == 0`.
- `error_count`, output, 32: mismatching vectors; saturates at 32'hffffffff.
- `first_error_index`, output, 32: index of the first mismatching vector. Meaningful only when `error_count != 0`.
- `error_channels`, output, `TEST_CHANNELS`: sticky OR of the per-bit mismatches.

## Operation
- Contains an `lfsr32` instance with `SEED`, reset together with the block, one step per clock.
- Expected generator `exp_gen`, `TEST_CHANNELS` bits:
  - Reset value is 0.
  - While `gen_cnt < TEST_CASES`: `exp_gen <= (exp_gen << 32) | rng_out`, truncated to `TEST_CHANNELS` bits, and `gen_cnt` increments.
  - After that it holds.
  - Vector index k is the value of `exp_gen` after k updates; index 0 is all zeros.
- Delay line:
  - `LATENCY` registers `d[1..LATENCY]`, each reset to 0, with `d[1] <= exp_gen` and `d[j] <= d[j-1]`.
  - The expected-compare value is `d[LATENCY]`, or `exp_gen` when `LATENCY` = 0.
- State machine, reset state ALIGN (or CHECK when `LATENCY` = 0):
  - ALIGN: `align_cnt` counts clocks; goes to CHECK after `LATENCY` rising edges.
  - CHECK: each edge compares `input_channels` with the expected-compare value and increments `chk_cnt`. Goes to DONE on the edge where `chk_cnt` reaches `TEST_CASES`.
  - DONE: terminal; only reset leaves it.
- On each CHECK edge with `mismatch = input_channels ^ expected != 0`:
  - `error_count` increments, saturating.
  - `error_channels |= mismatch`.
  - If `error_count` was 0, `first_error_index` is loaded with the current `chk_cnt`, i.e. the vector index.
- `output_channels = done ? input_channels : '0` (combinational).
- `pass = done & (error_count == 0)` (combinational).
- In DONE, `input_channels` no longer affects any result register.
- Reset asserted at any time, including mid-CHECK:
  - All registers clear immediately: counters, `exp_gen`, delay line, results, `done`.
  - The LFSR reseeds.
  - On release the sequence restarts from index 0; no partial results survive.

## Timing
- Edge n is the n-th rising `clk` edge after `reset` deasserts.
- The transmitter presents index k between edge k and edge k+1.
- Index k is sampled and compared at edge k + `LATENCY` + 1.
- Result registers update at that edge and are visible in the following cycle.
- `done` rises at edge `TEST_CASES` + `LATENCY` and stays high.
- The last comparison is made at the same edge as `done` rises; its result is already included when `done` is first seen high.
- Reset values: `done` 0, `pass` 0, `error_count` 0, `first_error_index` 0, `error_channels` 0, `output_channels` 0.
- `output_channels` has zero-cycle latency from `input_channels` once `done` = 1.
- `TEST_CHANNELS` not a multiple of 32: the shift truncates high bits, exactly as the transmitter does.
- `TEST_CHANNELS` < 32: only the low `rng_out` bits are kept.

## Test plan
- Matched transmitter looped back directly, `TEST_CHANNELS`=70, `TEST_CASES`=16, `LATENCY`=0 -> `done` rises at edge 16; `pass`=1; `error_count`=0; `error_channels`=0.
- Same loopback through 3 pipeline registers, `LATENCY`=3 -> `done` at edge 19, `pass`=1. The same delay with `LATENCY`=2 -> `pass`=0 and `error_count` > 0.
- Bit 5 flipped on index 7 only -> `error_count`=1; `first_error_index`=7; `error_channels`=1<<5; `pass`=0.
- Channel 69 stuck at 0 -> `error_channels` has only bit 69 set. `error_count` equals the reference-model count of vectors with bit 69 = 1; `first_error_index` is the first such index.
- `reset` pulsed low between edge 8 and edge 9 of a 16-vector run -> all outputs read 0 immediately. `done` then rises at edge 16 after release with `pass`=1.
- After `done`, random data driven on `input_channels` for 20 cycles -> `output_channels` equals `input_channels` in the same cycle. `error_count`, `first_error_index` and `error_channels` do not change.

Source files
------------

// File: rtl/bist_checker.sv
// Receive-side link BIST: regenerates the transmitter's LFSR vector stream,
// aligns it to the link latency, compares TEST_CASES vectors and then hands
// the link straight through to the router.

module lfsr32 #(
  parameter logic [31:0] SEED = 32'hdeadbeef
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rng_out
);

  // Galois right-shift LFSR, one step per clock, reseeded by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rng_out <= SEED;
    end else begin
      rng_out <= {1'b0, rng_out[31:1]} ^ ({32{rng_out[0]}} & 32'hB4BCD35C);
    end
  end

endmodule

module bist_checker #(
  parameter int          TEST_CHANNELS = 70,
  parameter logic [31:0] SEED          = 32'hdeadbeef,
  parameter int unsigned TEST_CASES    = 1000,
  parameter int          LATENCY       = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TEST_CHANNELS-1:0] input_channels,
  output logic [TEST_CHANNELS-1:0] output_channels,
  output logic                     done,
  output logic                     pass,
  output logic [31:0]              error_count,
  output logic [31:0]              first_error_index,
  output logic [TEST_CHANNELS-1:0] error_channels
);

  localparam int          W          = TEST_CHANNELS;
  localparam int          DLY_N      = (LATENCY > 0) ? LATENCY : 1;
  localparam logic [31:0] CASES      = 32'(TEST_CASES);
  localparam logic [31:0] CASES_LAST = CASES - 32'd1;
  localparam logic [3:0]  ALIGN_LAST = 4'(DLY_N - 1);

  typedef enum logic [1:0] {ALIGN, CHECK, DONE} state_t;
  localparam state_t RST_STATE = (LATENCY == 0) ? CHECK : ALIGN;

  logic [31:0]     rng_out;
  logic [W-1:0]    exp_gen;
  logic [31:0]     gen_cnt;
  logic [W+31:0]   gen_shift_p0;
  logic [W-1:0]    dly_p1 [1:DLY_N];
  logic [W-1:0]    expected_p0;
  logic [W-1:0]    mismatch_p0;
  state_t          state;
  logic [3:0]      align_cnt;
  logic [31:0]     chk_cnt;

  lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .rng_out (rng_out)
  );

  // Shifting the new 32-bit word in from the bottom; the concat's low W bits
  // give the truncation the transmitter applies for any channel count.
  assign gen_shift_p0 = {exp_gen, rng_out};

  // Expected-vector generator: one update per clock until TEST_CASES updates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_gen <= '0;
      gen_cnt <= '0;
    end else if (gen_cnt < CASES) begin
      exp_gen <= gen_shift_p0[W-1:0];
      gen_cnt <= gen_cnt + 32'd1;
    end
  end

  // Delay line matching the link's register stages
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 1; j <= DLY_N; j++) dly_p1[j] <= '0;
    end else begin
      dly_p1[1] <= exp_gen;
      for (int j = 2; j <= DLY_N; j++) dly_p1[j] <= dly_p1[j-1];
    end
  end

  assign expected_p0 = (LATENCY == 0) ? exp_gen : dly_p1[DLY_N];
  assign mismatch_p0 = input_channels ^ expected_p0;

  // Control FSM with comparison result registers; DONE freezes everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= RST_STATE;
      align_cnt         <= '0;
      chk_cnt           <= '0;
      done              <= 1'b0;
      error_count       <= '0;
      first_error_index <= '0;
      error_channels    <= '0;
    end else begin
      case (state)
        ALIGN: begin
          if (align_cnt == ALIGN_LAST) state <= CHECK;
          else align_cnt <= align_cnt + 4'd1;
        end
        CHECK: begin
          chk_cnt <= chk_cnt + 32'd1;
          if (mismatch_p0 != '0) begin
            if (error_count != 32'hffffffff) error_count <= error_count + 32'd1;
            error_channels <= error_channels | mismatch_p0;
            if (error_count == 32'd0) first_error_index <= chk_cnt;
          end
          if (chk_cnt == CASES_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= RST_STATE;
        end
      endcase
    end
  end

  assign pass            = done & (error_count == 32'd0);
  assign output_channels = done ? input_channels : '0;

endmodule
